// File: rtl/top_decode_pkg.sv
// Shared decode constants: datapath width, RV32I opcodes, decode FSM states.
// Imported by every decode-stage file.
package top_decode_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_MISC   = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RDWAIT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/top_decode_imm_gen.sv
// Combinational immediate generator and RV32I opcode legality check.
// Formats: I, S, B, U, J; R-type, MISC-MEM and SYSTEM yield zero.
module imm_gen
    import top_decode_pkg::*;
#(
    parameter int W = top_decode_pkg::XLEN
) (
    input  logic [W-1:0] i_inst,
    output logic [W-1:0] o_imm,
    output logic         o_illegal
);

    logic [31:0] w_i;
    logic [31:0] w_imm;

    assign w_i = i_inst[31:0];

    always_comb begin
        w_imm     = '0;
        o_illegal = 1'b0;
        unique case (w_i[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                w_imm = {{20{w_i[31]}}, w_i[31:20]};
            OP_STORE:
                w_imm = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
            OP_BRANCH:
                w_imm = {{19{w_i[31]}}, w_i[31], w_i[7],
                         w_i[30:25], w_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {w_i[31:12], 12'h000};
            OP_JAL:
                w_imm = {{11{w_i[31]}}, w_i[31], w_i[19:12],
                         w_i[20], w_i[30:21], 1'b0};
            OP_OP, OP_MISC, OP_SYSTEM:
                w_imm = '0;
            default:
                o_illegal = 1'b1;
        endcase
    end

    assign o_imm = W'($signed(w_imm));

endmodule

// File: rtl/top_decode.sv
// Decode stage: latch inst/PC, wait one cycle for register file read
// data, then register operands, immediate and control fields.
module top_decode
    import top_decode_pkg::*;
#(
    parameter int XLEN = top_decode_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            phase_decode,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] curr_pc_fd,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] curr_pc_de,
    output logic [XLEN-1:0] rs1_de,
    output logic [XLEN-1:0] rs2_de,
    output logic [XLEN-1:0] imm_de,
    output logic [4:0]      rd_addr_de,
    output logic [6:0]      opcode_de,
    output logic [2:0]      funct3_de,
    output logic            funct7b5_de,
    output logic            illegal_de,
    output logic            stall_decode
);

    state_t          r_state;
    logic [XLEN-1:0] r_inst_q;
    logic [XLEN-1:0] r_pc_q;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic [4:0]      w_rs1_q;
    logic [4:0]      w_rs2_q;

    assign w_rs1_q = r_inst_q[19:15];
    assign w_rs2_q = r_inst_q[24:20];

    // Addresses go out straight from fetch so read data lands in RDWAIT.
    assign rs1_addr = (r_state == S_IDLE) ? inst[19:15] : w_rs1_q;
    assign rs2_addr = (r_state == S_IDLE) ? inst[24:20] : w_rs2_q;

    assign stall_decode = rst_n & (r_state == S_IDLE) & phase_decode;

    imm_gen #(.W(XLEN)) u_imm_gen (
        .i_inst    (r_inst_q),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_inst_q    <= '0;
            r_pc_q      <= '0;
            curr_pc_de  <= '0;
            rs1_de      <= '0;
            rs2_de      <= '0;
            imm_de      <= '0;
            rd_addr_de  <= '0;
            opcode_de   <= '0;
            funct3_de   <= '0;
            funct7b5_de <= 1'b0;
            illegal_de  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (phase_decode) begin
                        r_inst_q <= inst;
                        r_pc_q   <= curr_pc_fd;
                        r_state  <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (phase_decode) begin
                        curr_pc_de  <= r_pc_q;
                        rs1_de      <= (w_rs1_q == 5'd0) ? '0 : rs1_data;
                        rs2_de      <= (w_rs2_q == 5'd0) ? '0 : rs2_data;
                        imm_de      <= w_imm;
                        rd_addr_de  <= w_illegal ? 5'd0 : r_inst_q[11:7];
                        opcode_de   <= r_inst_q[6:0];
                        funct3_de   <= r_inst_q[14:12];
                        funct7b5_de <= r_inst_q[30];
                        illegal_de  <= w_illegal;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!phase_decode) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/top_decode.md
TOP_DECODE -- requirements
Module: top_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; RISC-V opcodes and XLEN SHALL come from core_general.vh.
REQ-002 SHALL have clk  input  1  global clock, rising-edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have phase_decode  input  1  decode phase from state machine.
REQ-005 SHALL have inst  input  XLEN  instruction from fetch.
REQ-006 SHALL have curr_pc_fd  input  XLEN  PC of inst from fetch.
REQ-007 SHALL have rs1_data / rs2_data  input  XLEN each  register file read data, valid 1 clk after address.
REQ-008 SHALL have rs1_addr / rs2_addr  output  5 each  register file read addresses.
REQ-009 SHALL have curr_pc_de  output  XLEN  PC for execute.
REQ-010 SHALL have rs1_de / rs2_de  output  XLEN each  operands for execute.
REQ-011 SHALL have imm_de  output  XLEN  sign-extended immediate.
REQ-012 SHALL have rd_addr_de  output  5  destination register.
REQ-013 SHALL have opcode_de  output  7, funct3_de  output  3, funct7b5_de  output  1  control fields.
REQ-014 SHALL have illegal_de  output  1  opcode not in RV32I base set.
REQ-015 SHALL have stall_decode  output  1  hold decode phase.

Function
REQ-016 SHALL implement FSM states IDLE, RDWAIT, DONE.
REQ-017 IDLE with phase_decode=1: inst_q<=inst, pc_q<=curr_pc_fd, go RDWAIT; stall_decode=1 this cycle only.
REQ-018 rs1_addr/rs2_addr SHALL be inst[19:15]/inst[24:20] in IDLE, inst_q fields otherwise (combinational).
REQ-019 RDWAIT with phase_decode=1: all *_de outputs SHALL load from inst_q/pc_q/rs*_data at the closing edge, go DONE.
REQ-020 RDWAIT with phase_decode=0 (abort): go IDLE, *_de outputs unchanged.
REQ-021 DONE: outputs held; phase_decode=0 -> IDLE; phase_decode=1 -> stay DONE (no re-decode).
REQ-022 Total latency: 2 clk from phase_decode rise to valid *_de; stall_decode SHALL be 0 outside REQ-017 cycle.
REQ-023 rs1_de / rs2_de SHALL be 0 when the corresponding address is 0, regardless of rs*_data.
REQ-024 imm_de by format, sign bit inst[31]: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 = 0), J (JAL, bit0=0); R-type and SYSTEM -> 0.
REQ-025 illegal_de SHALL be 1 for any opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}; then imm_de=0, rd_addr_de=0.
REQ-026 curr_pc_de SHALL equal pc_q unmodified.

Reset
REQ-027 rst_n=0 SHALL force state IDLE, inst_q=0, pc_q=0, all *_de=0, illegal_de=0, stall_decode=0 immediately (async).
REQ-028 Reset mid-RDWAIT SHALL discard the pending decode; first post-reset decode SHALL behave as REQ-017.

Structure
REQ-029 Opcode constants, XLEN, and FSM state encoding SHALL reside in core_general.vh.
REQ-030 Immediate generation SHALL be a combinational sub-module imm_gen (inst in, imm and illegal out).

Verification
REQ-031 inst=0xFFF10093 (addi x1,x2,-1), rs1_data=0x10 -> rs1_addr=2, rd_addr_de=1, imm_de=0xFFFFFFFF, rs1_de=0x10, opcode_de=0x13, 2 clk latency.
REQ-032 inst=0x123452B7 (lui x5) -> imm_de=0x12345000, rd_addr_de=5, illegal_de=0.
REQ-033 inst=0x00322423 (sw x3,8(x4)), rs2_data=0xCAFEBABE -> rs1_addr=4, rs2_addr=3, imm_de=8, rs2_de=0xCAFEBABE.
REQ-034 inst=0x00000000 -> illegal_de=1, imm_de=0, rd_addr_de=0.
REQ-035 rs1 field=0 with rs1_data=0xDEAD -> rs1_de=0.
REQ-036 phase_decode dropped in RDWAIT, and separately rst_n pulsed in RDWAIT -> outputs keep prior values (abort) / all zero (reset), state IDLE.
